// File: rtl/chan2push.sv
// Valid/ready channel to FIFO push-port adapter: a DEPTH-entry ring plus a
// registered output stage absorb sink-full stalls while keeping word order.
module chan2push #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] idata,
    input  logic             ivalid,
    output logic             iready,
    output logic [WIDTH-1:0] odata,
    output logic             owren,
    input  logic             ofull
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] ring_q [DEPTH];
    logic [AW-1:0]    rdptr_q, rdptr_d;
    logic [AW-1:0]    wrptr_q, wrptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             iready_q, iready_d;
    logic             owren_q, owren_d;
    logic [WIDTH-1:0] odata_q, odata_d;
    logic             in_fire_s, free_s, pop_s, push_s, bypass_s;

    // Handshake decode, output-stage refill and ring bookkeeping.
    always_comb begin
        in_fire_s = ivalid && iready_q;
        free_s    = !owren_q || !ofull;
        pop_s     = free_s && (count_q != {CW{1'b0}});
        bypass_s  = free_s && (count_q == {CW{1'b0}}) && in_fire_s;
        push_s    = in_fire_s && !bypass_s;

        odata_d = odata_q;
        owren_d = owren_q;
        rdptr_d = rdptr_q;
        wrptr_d = wrptr_q;

        // Older ring words always take precedence over the incoming word.
        if (free_s) begin
            if (pop_s) begin
                odata_d = ring_q[rdptr_q];
                owren_d = 1'b1;
                rdptr_d = rdptr_q + PTR_ONE;
            end else if (in_fire_s) begin
                odata_d = idata;
                owren_d = 1'b1;
            end else begin
                owren_d = 1'b0;
            end
        end else begin
            odata_d = odata_q;
            owren_d = owren_q;
        end

        if (push_s) begin
            wrptr_d = wrptr_q + PTR_ONE;
        end else begin
            wrptr_d = wrptr_q;
        end

        count_d  = count_q + CW'(push_s) - CW'(pop_s);
        iready_d = (count_d < DEPTH_C);
    end

    // Control and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdptr_q  <= {AW{1'b0}};
            wrptr_q  <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            iready_q <= 1'b1;
            owren_q  <= 1'b0;
            odata_q  <= {WIDTH{1'b0}};
        end else begin
            rdptr_q  <= rdptr_d;
            wrptr_q  <= wrptr_d;
            count_q  <= count_d;
            iready_q <= iready_d;
            owren_q  <= owren_d;
            odata_q  <= odata_d;
        end
    end

    // Ring storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (push_s) begin
            ring_q[wrptr_q] <= idata;
        end
    end

    assign iready = iready_q;
    assign owren  = owren_q;
    assign odata  = odata_q;

endmodule

// File: tb/tb_chan2push.sv
// Directed and scoreboard-checked bench for chan2push (WIDTH=8, DEPTH=4).
module tb_chan2push;

    localparam int DEPTH = 4;

    logic       clock;
    logic       resetn;
    logic [7:0] idata;
    logic       ivalid;
    logic       iready;
    logic [7:0] odata;
    logic       owren;
    logic       ofull;

    int n_cmp = 0;
    int n_err = 0;

    chan2push #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .resetn(resetn),
        .idata (idata),
        .ivalid(ivalid),
        .iready(iready),
        .odata (odata),
        .owren (owren),
        .ofull (ofull)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ivalid = 1'b0; ofull = 1'b0; idata = 8'h00;
        tick(); tick();
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL reset_iready: got %b want 1", iready); end
        n_cmp++; if (owren !== 1'b0) begin n_err++; $display("FAIL reset_owren: got %b want 0", owren); end
        n_cmp++; if (odata !== 8'h00) begin n_err++; $display("FAIL reset_odata: got %h want 00", odata); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        ofull = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ivalid = 1'b1; idata = 8'(i);
            tick();
            n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL stream_iready[%0d]: got %b want 1", i, iready); end
            n_cmp++; if (owren !== 1'b1) begin n_err++; $display("FAIL stream_owren[%0d]: got %b want 1", i, owren); end
            n_cmp++; if (odata !== 8'(i)) begin n_err++; $display("FAIL stream_odata[%0d]: got %h want %h", i, odata, 8'(i)); end
        end
        ivalid = 1'b0;
        tick();
        n_cmp++; if (owren !== 1'b0) begin n_err++; $display("FAIL stream_idle_owren: got %b want 0", owren); end
    endtask

    task automatic test_stall_fill();
        ofull = 1'b1;
        for (int n = 0; n < 5; n++) begin
            ivalid = 1'b1; idata = 8'(8'hA0 + n);
            tick();
            n_cmp++; if (owren !== 1'b1 || odata !== 8'hA0) begin n_err++; $display("FAIL fill_hold[%0d]: got %b/%h want 1/a0", n, owren, odata); end
            n_cmp++; if (iready !== (n < 4)) begin n_err++; $display("FAIL fill_iready[%0d]: got %b want %b", n, iready, (n < 4)); end
        end
        idata = 8'hA5;
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++; if (owren !== 1'b1 || odata !== 8'hA0) begin n_err++; $display("FAIL full_hold[%0d]: got %b/%h want 1/a0", n, owren, odata); end
            n_cmp++; if (iready !== 1'b0) begin n_err++; $display("FAIL full_iready[%0d]: got %b want 0", n, iready); end
        end
    endtask

    task automatic test_drain_wrap();
        ofull = 1'b0;
        tick();
        n_cmp++; if (odata !== 8'hA1 || owren !== 1'b1) begin n_err++; $display("FAIL drain_first: got %b/%h want 1/a1", owren, odata); end
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL drain_iready_rise: got %b want 1", iready); end
        tick();
        n_cmp++; if (odata !== 8'hA2 || iready !== 1'b1) begin n_err++; $display("FAIL drain_push_pop: got %h/%b want a2/1", odata, iready); end
        ivalid = 1'b0;
        for (int n = 3; n < 6; n++) begin
            tick();
            n_cmp++; if (owren !== 1'b1 || odata !== 8'(8'hA0 + n)) begin n_err++; $display("FAIL drain_word[%0d]: got %b/%h want 1/%h", n, owren, odata, 8'(8'hA0 + n)); end
        end
        tick();
        n_cmp++; if (owren !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", owren); end
    endtask

    task automatic test_simultaneous();
        ofull = 1'b1;
        for (int n = 0; n < 3; n++) begin
            ivalid = 1'b1; idata = 8'(8'hB0 + n);
            tick();
        end
        n_cmp++; if (odata !== 8'hB0 || iready !== 1'b1) begin n_err++; $display("FAIL simul_setup: got %h/%b want b0/1", odata, iready); end
        ofull = 1'b0; idata = 8'hB3;
        tick();
        n_cmp++; if (odata !== 8'hB1 || owren !== 1'b1) begin n_err++; $display("FAIL simul_out: got %b/%h want 1/b1", owren, odata); end
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL simul_iready: got %b want 1", iready); end
        ivalid = 1'b0;
        tick();
        n_cmp++; if (odata !== 8'hB2) begin n_err++; $display("FAIL simul_next0: got %h want b2", odata); end
        tick();
        n_cmp++; if (odata !== 8'hB3) begin n_err++; $display("FAIL simul_next1: got %h want b3", odata); end
        tick();
        n_cmp++; if (owren !== 1'b0) begin n_err++; $display("FAIL simul_empty: got %b want 0", owren); end
    endtask

    task automatic test_reset_midstream();
        ofull = 1'b1;
        for (int n = 0; n < 4; n++) begin
            ivalid = 1'b1; idata = 8'(8'hC0 + n);
            tick();
        end
        ivalid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_cmp++; if (iready !== 1'b1) begin n_err++; $display("FAIL midrst_iready: got %b want 1", iready); end
        n_cmp++; if (owren !== 1'b0) begin n_err++; $display("FAIL midrst_owren: got %b want 0", owren); end
        n_cmp++; if (odata !== 8'h00) begin n_err++; $display("FAIL midrst_odata: got %h want 00", odata); end
        #1 resetn = 1'b1;
        ofull = 1'b0; ivalid = 1'b1; idata = 8'h5A;
        tick();
        n_cmp++; if (owren !== 1'b1 || odata !== 8'h5A) begin n_err++; $display("FAIL midrst_first: got %b/%h want 1/5a", owren, odata); end
        ivalid = 1'b0;
        tick();
        n_cmp++; if (owren !== 1'b0) begin n_err++; $display("FAIL midrst_discard: got %b want 0", owren); end
    endtask

    task automatic test_random_stress();
        logic [7:0] q[$];
        logic [7:0] seq;
        logic [7:0] prev_odata;
        logic [7:0] exp;
        logic       in_fire_p, out_fire_p, hold_p;
        seq = 8'h00;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc < 9990) begin
                ivalid = 1'($urandom_range(1, 0));
                ofull  = 1'($urandom_range(1, 0));
            end else begin
                ivalid = 1'b0;
                ofull  = 1'b0;
            end
            idata      = seq;
            in_fire_p  = ivalid && iready;
            out_fire_p = owren && !ofull;
            hold_p     = owren && ofull;
            prev_odata = odata;
            if (in_fire_p) begin
                n_cmp++; if ((q.size() - int'(owren)) >= DEPTH) begin n_err++; $display("FAIL stress_overflow[%0d]: accepted with ring count %0d", cyc, q.size() - int'(owren)); end
            end
            tick();
            if (out_fire_p) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL stress_extra[%0d]: got %h want nothing", cyc, prev_odata);
                end else begin
                    exp = q.pop_front();
                    n_cmp++; if (prev_odata !== exp) begin n_err++; $display("FAIL stress_commit[%0d]: got %h want %h", cyc, prev_odata, exp); end
                end
            end
            if (in_fire_p) begin
                q.push_back(seq);
                seq = seq + 8'h01;
            end
            n_cmp++; if (owren !== (q.size() != 0)) begin n_err++; $display("FAIL stress_owren[%0d]: got %b want %b", cyc, owren, (q.size() != 0)); end
            if (q.size() != 0) begin
                n_cmp++; if (odata !== q[0]) begin n_err++; $display("FAIL stress_odata[%0d]: got %h want %h", cyc, odata, q[0]); end
            end
            n_cmp++; if (iready !== ((q.size() - int'(q.size() != 0)) < DEPTH)) begin n_err++; $display("FAIL stress_iready[%0d]: got %b in-flight %0d", cyc, iready, q.size()); end
            if (hold_p) begin
                n_cmp++; if (odata !== prev_odata || owren !== 1'b1) begin n_err++; $display("FAIL stress_stall_stable[%0d]: got %b/%h want 1/%h", cyc, owren, odata, prev_odata); end
            end
        end
        n_cmp++; if (q.size() != 0 || owren !== 1'b0) begin n_err++; $display("FAIL stress_final: got %0d in flight, owren %b want 0/0", q.size(), owren); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_drain_wrap();
        test_simultaneous();
        test_reset_midstream();
        test_random_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
